// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction loader and the bit-serial CPU core.
package cpu_pkg;

  // Field widths of the instruction word and of the switch byte.
  localparam int OPCODE_W = 4;
  localparam int INSTR_W  = 12;
  localparam int BYTE_W   = 8;

  // Load FSM encodings. The value 2'd3 is unused and recovers to WAIT_LO.
  localparam logic [1:0] LD_WAIT_LO = 2'd0;
  localparam logic [1:0] LD_WAIT_HI = 2'd1;
  localparam logic [1:0] LD_LOADED  = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: synchroniser, debounce counter and press detection.
// press is the internal one-cycle event in the cycle after the debounced level rises.
// btn_edge is the registered copy of press, so it is high in the following cycle.
module btn_debounce #(
  parameter int  SYNC_STAGES     = 2,
  parameter int  DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press,
  output logic btn_edge
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   btn_sync_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   deb_r;
  logic                   deb_nxt_s;
  logic                   deb_prev_r;
  logic                   btn_edge_r;

  assign btn_sync_s = sync_r[SYNC_STAGES-1];
  assign press      = deb_r & ~deb_prev_r;
  assign btn_edge   = btn_edge_r;

  // Shift the raw button through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Count consecutive cycles that disagree with the debounced level; toggle when the count is full.
  always_comb begin
    cnt_nxt_s = cnt_r;
    deb_nxt_s = deb_r;
    if (btn_sync_s == deb_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      deb_nxt_s = ~deb_r;
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Hold the debounce state and register the press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      deb_r      <= 1'b0;
      deb_prev_r <= 1'b0;
      btn_edge_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      deb_r      <= deb_nxt_s;
      deb_prev_r <= deb_r;
      btn_edge_r <= press;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: two button presses assemble {opcode, instr} from the switch byte,
// a third press is the execute press that hands the instruction to the core.
// opcode/instr only change together on the high-byte press, so the core never sees a
// half-loaded word; the previous instruction stays visible while the next one loads.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   data_in,
  input  logic                btn_raw,
  output logic [OPCODE_W-1:0] opcode,
  output logic [INSTR_W-1:0]  instr,
  output logic                inst_done,
  output logic                btn_edge,
  output logic [1:0]          load_state
);

  logic                press_s;
  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [BYTE_W-1:0]   lo_byte_r;
  logic [BYTE_W-1:0]   lo_byte_nxt_s;
  logic [OPCODE_W-1:0] opcode_r;
  logic [OPCODE_W-1:0] opcode_nxt_s;
  logic [INSTR_W-1:0]  instr_r;
  logic [INSTR_W-1:0]  instr_nxt_s;
  logic                inst_done_r;
  logic                inst_done_nxt_s;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .press    (press_s),
    .btn_edge (btn_edge)
  );

  assign opcode     = opcode_r;
  assign instr      = instr_r;
  assign inst_done  = inst_done_r;
  assign load_state = state_r;

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LD_WAIT_LO;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: every press advances one step; the unused encoding falls back to WAIT_LO.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LD_WAIT_LO: begin
        if (press_s) begin
          state_nxt_s = LD_WAIT_HI;
        end else begin
          state_nxt_s = LD_WAIT_LO;
        end
      end
      LD_WAIT_HI: begin
        if (press_s) begin
          state_nxt_s = LD_LOADED;
        end else begin
          state_nxt_s = LD_WAIT_HI;
        end
      end
      LD_LOADED: begin
        if (press_s) begin
          state_nxt_s = LD_WAIT_LO;
        end else begin
          state_nxt_s = LD_LOADED;
        end
      end
      default: begin
        state_nxt_s = LD_WAIT_LO;
      end
    endcase
  end

  // Datapath next values: stage the low byte, commit both fields at once on the high byte.
  // inst_done survives the execute press cycle and drops once the FSM is back in WAIT_LO.
  always_comb begin
    lo_byte_nxt_s   = lo_byte_r;
    opcode_nxt_s    = opcode_r;
    instr_nxt_s     = instr_r;
    inst_done_nxt_s = inst_done_r;
    case (state_r)
      LD_WAIT_LO: begin
        inst_done_nxt_s = 1'b0;
        if (press_s) begin
          lo_byte_nxt_s = data_in;
        end else begin
          lo_byte_nxt_s = lo_byte_r;
        end
      end
      LD_WAIT_HI: begin
        if (press_s) begin
          opcode_nxt_s    = data_in[7:4];
          instr_nxt_s     = {data_in[3:0], lo_byte_r};
          inst_done_nxt_s = 1'b1;
        end else begin
          inst_done_nxt_s = inst_done_r;
        end
      end
      LD_LOADED: begin
        inst_done_nxt_s = inst_done_r;
      end
      default: begin
        inst_done_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_byte_r   <= {BYTE_W{1'b0}};
      opcode_r    <= {OPCODE_W{1'b0}};
      instr_r     <= {INSTR_W{1'b0}};
      inst_done_r <= 1'b0;
    end else begin
      lo_byte_r   <= lo_byte_nxt_s;
      opcode_r    <= opcode_nxt_s;
      instr_r     <= instr_nxt_s;
      inst_done_r <= inst_done_nxt_s;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a small press model pushes expected
// {opcode, instr} words into a scoreboard, popped whenever inst_done rises.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        btn_raw;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        btn_edge;
  logic [1:0]  load_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sb_q[$];
  int          edge_cnt  = 0;
  logic        prev_done = 1'b0;

  logic [1:0]  m_state   = 2'd0;
  logic [7:0]  m_lo      = 8'h00;
  int          m_presses = 0;

  instr_loader dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .btn_raw    (btn_raw),
    .opcode     (opcode),
    .instr      (instr),
    .inst_done  (inst_done),
    .btn_edge   (btn_edge),
    .load_state (load_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fpat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Reference behaviour of one debounced press.
  task automatic model_press(input logic [7:0] d);
    m_presses++;
    case (m_state)
      2'd0: begin m_lo = d; m_state = 2'd1; end
      2'd1: begin sb_q.push_back({d, m_lo}); m_state = 2'd2; end
      default: m_state = 2'd0;
    endcase
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_opcode"}, 32'(opcode), 32'h0);
    check_eq({tag, "_instr"}, 32'(instr), 32'h0);
    check_eq({tag, "_done"}, 32'(inst_done), 32'h0);
    check_eq({tag, "_edge"}, 32'(btn_edge), 32'h0);
    check_eq({tag, "_state"}, 32'(load_state), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero(tag);
    rst = 1'b0;
    m_state = 2'd0;
  endtask

  task automatic press_release(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    btn_raw = 1'b1;
    model_press(d);
    repeat (12) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Scoreboard and press counter, sampled away from the active edge.
  always @(negedge clk) begin
    if (btn_edge) edge_cnt++;
    if (inst_done && !prev_done) begin
      check_eq("done_with_edge", 32'(btn_edge), 32'h1);
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'h1);
      if (sb_q.size() != 0) begin
        check_eq("sb_word", 32'({opcode, instr}), 32'(sb_q.pop_front()));
      end
    end
    prev_done = inst_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e0;
    bit  found;
    rst     = 1'b1;
    btn_raw = 1'b1;
    data_in = 8'h00;

    // 1: reset with button held, then exact press latency.
    repeat (2) @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b0;
    model_press(8'h00);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("latency_%0d", i), 32'(btn_edge), 32'(i == 7));
    end
    check_eq("first_press_state", 32'(load_state), 32'h1);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    do_reset("rst2");

    // 2: load 0x34 then 0xA5.
    press_release(8'h34);
    check_eq("lo_state", 32'(load_state), 32'h1);
    check_eq("lo_done", 32'(inst_done), 32'h0);
    press_release(8'hA5);
    check_eq("hi_state", 32'(load_state), 32'h2);
    check_eq("hi_done", 32'(inst_done), 32'h1);
    check_eq("hi_opcode", 32'(opcode), 32'hA);
    check_eq("hi_instr", 32'(instr), 32'h534);

    // 3: execute press.
    @(negedge clk);
    btn_raw = 1'b1;
    model_press(data_in);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (btn_edge) found = 1'b1;
    end
    check_eq("exec_edge_seen", 32'(found), 32'h1);
    check_eq("exec_done_same", 32'(inst_done), 32'h1);
    @(negedge clk);
    check_eq("exec_done_next", 32'(inst_done), 32'h0);
    check_eq("exec_state", 32'(load_state), 32'h0);
    check_eq("exec_opcode", 32'(opcode), 32'hA);
    check_eq("exec_instr", 32'(instr), 32'h534);
    repeat (4) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);

    // 5a: a single low-byte press leaves the visible instruction alone.
    press_release(8'hFF);
    check_eq("atom_state", 32'(load_state), 32'h1);
    check_eq("atom_opcode", 32'(opcode), 32'hA);
    check_eq("atom_instr", 32'(instr), 32'h534);
    check_eq("atom_done", 32'(inst_done), 32'h0);

    // 4: bouncy press completes the instruction with exactly one pulse.
    e0 = edge_cnt;
    @(negedge clk);
    data_in = 8'h6C;
    model_press(8'h6C);
    btn_raw = 1'b1; @(negedge clk);
    btn_raw = 1'b0; @(negedge clk);
    btn_raw = 1'b1; @(negedge clk);
    btn_raw = 1'b0; @(negedge clk);
    btn_raw = 1'b1;
    repeat (10) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("bounce_pulses", 32'(edge_cnt - e0), 32'h1);
    check_eq("bounce_opcode", 32'(opcode), 32'h6);
    check_eq("bounce_instr", 32'(instr), 32'hCFF);

    // 4b: a 2-cycle glitch does nothing.
    e0 = edge_cnt;
    @(negedge clk);
    btn_raw = 1'b1;
    repeat (2) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("glitch_pulses", 32'(edge_cnt - e0), 32'h0);
    check_eq("glitch_state", 32'(load_state), 32'h2);
    check_eq("glitch_done", 32'(inst_done), 32'h1);

    // 5b: reset mid-load discards the staged byte.
    press_release(8'h00);
    check_eq("exec2_done", 32'(inst_done), 32'h0);
    press_release(8'h77);
    check_eq("midload_state", 32'(load_state), 32'h1);
    do_reset("rst_midload");
    press_release(8'h01);
    press_release(8'h92);
    check_eq("reload_opcode", 32'(opcode), 32'h9);
    check_eq("reload_instr", 32'(instr), 32'h201);

    // 6: long hold with data toggling every cycle.
    press_release(8'h00);
    e0 = edge_cnt;
    @(negedge clk);
    data_in = fpat(0);
    btn_raw = 1'b1;
    model_press(fpat(6));
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      data_in = fpat(i);
    end
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("hold_pulses", 32'(edge_cnt - e0), 32'h1);
    check_eq("hold_state", 32'(load_state), 32'h1);
    press_release(8'hC3);
    check_eq("hold_lo_byte", 32'(instr[7:0]), 32'(fpat(6)));
    check_eq("hold_opcode", 32'(opcode), 32'hC);

    // Drain checks.
    repeat (4) @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'h0);
    check_eq("total_pulses", 32'(edge_cnt), 32'(m_presses));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
